delay_int16_credit_fifo: RTL and testbench

- Downstream stage of the fixed-latency INT16 delay line.
- The delay line cannot stall, so this block absorbs its output stream into a FIFO and presents a valid/ready interface to the consumer.
- It also issues credits to the producer upstream of the delay line, so that data in flight through the delay can never overflow the FIFO.
- Credit count covers both FIFO occupancy and in-flight items; the delay-line latency is transparent to this block.

---
 rtl/delay_int16_credit_fifo.sv | 138 +++++++++++++
 tb/tb_delay_int16_credit_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_int16_credit_fifo.sv
// Credit-managed fall-through FIFO behind a non-stalling INT16 delay line.
// Optional high-water-mark output enabled by DELAY_INT16_CREDIT_FIFO_HWM_EN.
module delay_int16_credit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issue,
  output logic                       credit_ok,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
  output logic [$clog2(DEPTH+1)-1:0] hwm,
`endif
  output logic                       credit_err
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          overflow_q, overflow_d;
  logic          credit_err_q, credit_err_d;

  logic pop;
  logic push;
  logic full;
  logic take;
  logic starve;

  always_comb begin
    pop    = (count_q != '0) && out_ready;
    full   = (count_q == FULL);
    push   = in_valid && (!full || pop);
    take   = issue && (credits_q != '0);
    starve = issue && (credits_q == '0);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      if (wr_ptr_q == LAST) wr_ptr_d = '0;
      else                  wr_ptr_d = wr_ptr_q + PW'(1);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      if (rd_ptr_q == LAST) rd_ptr_d = '0;
      else                  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pops can exceed issues only under illegal forced traffic; hold at DEPTH.
  always_comb begin
    credits_d = credits_q;
    unique case ({take, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = (credits_q == FULL) ? FULL
                                               : credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    overflow_d   = overflow_q | (in_valid && full && !pop);
    credit_err_d = credit_err_q | starve;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      credits_q    <= FULL;
      overflow_q   <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      credits_q    <= credits_d;
      overflow_q   <= overflow_d;
      credit_err_q <= credit_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
  end

  always_ff @(posedge clock) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`endif

  // Head word is masked when empty so out_data reads 0 out of reset.
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign credit_ok  = (credits_q != '0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_delay_int16_credit_fifo.sv
// Scoreboard bench: DEPTH=8 instance behind a 6-stage delay model,
// plus a DEPTH=5 instance for pointer wrap.
module tb_delay_int16_credit_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue = 1'b0;
  logic        credit_ok;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        overflow;
  logic        credit_err;

  logic        b_issue = 1'b0;
  logic        b_credit_ok;
  logic        b_in_valid = 1'b0;
  logic [15:0] b_in_data = '0;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic        b_out_ready = 1'b0;
  logic [2:0]  b_count;
  logic        b_overflow;
  logic        b_credit_err;
`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
  logic [3:0]  hwm;
  logic [2:0]  b_hwm;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] b_exp[$];

  logic        lv = 1'b0;
  logic [15:0] ld = '0;
  logic        fv = 1'b0;
  logic [15:0] fd = '0;
  logic [5:0]  dl_v;
  logic [15:0] dl_d [6];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) dl_v <= '0;
    else       dl_v <= {dl_v[4:0], issue & lv};
    dl_d[0] <= ld;
    for (int i = 1; i < 6; i++) dl_d[i] <= dl_d[i-1];
  end

  assign in_valid = dl_v[5] | fv;
  assign in_data  = fv ? fd : dl_d[5];

  delay_int16_credit_fifo #(.WIDTH(16), .DEPTH(8)) u_dut (
    .clock(clock), .reset(reset), .issue(issue),
    .credit_ok(credit_ok), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .overflow(overflow),
`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
    .hwm(hwm),
`endif
    .credit_err(credit_err)
  );

  delay_int16_credit_fifo #(.WIDTH(16), .DEPTH(5)) u_dut5 (
    .clock(clock), .reset(reset), .issue(b_issue),
    .credit_ok(b_credit_ok), .in_valid(b_in_valid), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready),
    .count(b_count), .overflow(b_overflow),
`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
    .hwm(b_hwm),
`endif
    .credit_err(b_credit_err)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
    end
    if (!reset && b_out_valid && b_out_ready) begin
      if (b_exp.size() == 0) chk("b_pop_unexpected", 1, 0);
      else chk("b_out_data", {16'h0, b_out_data}, {16'h0, b_exp.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue = 0; lv = 0; fv = 0; out_ready = 0;
    b_in_valid = 0; b_out_ready = 0;
    exp_q.delete();
    b_exp.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic issue_word(input logic [15:0] d);
    issue = 1; lv = 1; ld = d;
    exp_q.push_back(d);
    tick();
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) begin
      chk("credit_ok_fill", credit_ok, 1);
      issue_word(16'(i));
    end
    issue = 0; lv = 0;
    chk("credit_ok_drop", credit_ok, 0);
    repeat (10) tick();
    chk("count_full", count, 8);
  endtask

  task automatic wait_empty();
    int n = 0;
    out_ready = 1;
    while (count != 0 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 0;
    chk("drain_done", count, 0);
  endtask

  task automatic b_step(input logic p, input logic q, input logic [15:0] d);
    b_in_valid = p; b_in_data = d; b_out_ready = q;
    if (p) b_exp.push_back(d);
    tick();
    b_in_valid = 0; b_out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int bn;
    tick();
    do_reset();
    repeat (5) tick();
    chk("rst_credit_ok", credit_ok, 1);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_out_data", out_data, 0);

    fill8();
    chk("full_out_valid", out_valid, 1);
`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
    chk("hwm_full", hwm, 8);
`endif
    wait_empty();
    chk("drained_credit_ok", credit_ok, 1);
    chk("drained_out_valid", out_valid, 0);

    do_reset();
    out_ready = 1;
    for (int i = 0; i < 50; i++) begin
      chk("stream_credit_ok", credit_ok, 1);
      issue_word(16'h8000 + 16'(i));
    end
    issue = 0; lv = 0;
    repeat (8) tick();
    wait_empty();
    chk("stream_overflow", overflow, 0);
    chk("stream_credit_err", credit_err, 0);

    do_reset();
    fill8();
    fv = 1; fd = 16'hDEAD; out_ready = 0;
    tick();
    fv = 0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    repeat (3) tick();
    chk("ovf_sticky", overflow, 1);
`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
    chk("hwm_ovf", hwm, 8);
`endif
    fv = 1; fd = 16'hDEAD; out_ready = 1;
    exp_q.push_back(16'hDEAD);
    tick();
    fv = 0; out_ready = 0;
    chk("ovf_pop_count", count, 8);
    chk("ovf_still", overflow, 1);
    wait_empty();
    chk("ovf_after_drain", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    fill8();
    chk("cerr_pre", credit_err, 0);
    issue = 1; lv = 0;
    tick();
    issue = 0;
    chk("cerr_set", credit_err, 1);
    chk("cerr_no_credit", credit_ok, 0);
    chk("cerr_no_launch", count, 8);
    issue = 1; lv = 0; out_ready = 1;
    tick();
    issue = 0; out_ready = 0;
    chk("cerr_pop_credit", credit_ok, 1);
    chk("cerr_sticky", credit_err, 1);
    chk("cerr_pop_count", count, 7);
    repeat (8) tick();
    chk("cerr_nothing_late", count, 7);
    wait_empty();

    do_reset();
    bn = 0;
    for (int g = 0; g < 4; g++) begin
      b_step(1, 0, 16'h0100 + 16'(bn)); bn++;
      b_step(1, 0, 16'h0100 + 16'(bn)); bn++;
      if (g == 3) chk("b_peak", b_count, 5);
      b_step(0, 1, 16'h0);
    end
    chk("b_mid_count", b_count, 4);
    for (int k = 0; k < 5; k++) begin
      b_step(1, 1, 16'h0100 + 16'(bn)); bn++;
    end
    chk("b_steady_count", b_count, 4);
    for (int k = 0; k < 20 && b_count != 0; k++) b_step(0, 1, 16'h0);
    chk("b_drained", b_count, 0);
    chk("b_overflow", b_overflow, 0);
    chk("b_credit_err", b_credit_err, 0);
    chk("b_words", bn, 13);
`ifdef DELAY_INT16_CREDIT_FIFO_HWM_EN
    chk("b_hwm", b_hwm, 5);
`endif

    chk("sb_empty", exp_q.size(), 0);
    chk("b_sb_empty", b_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
